// File: rtl/riscv_perf_dump_if.sv
// Bundles the CSR initiator port and the counter output stream.
// The dump engine is the master side. The CSR arbiter and the stream consumer are the slave side.
interface riscv_perf_dump_if;
    logic        csr_req_o;
    logic        csr_gnt_i;
    logic        csr_access_o;
    logic [11:0] csr_addr_o;
    logic [31:0] csr_wdata_o;
    logic [1:0]  csr_op_o;
    logic [31:0] csr_rdata_i;
    logic        out_valid_o;
    logic        out_ready_i;
    logic [31:0] out_data_o;
    logic [4:0]  out_index_o;
    logic        out_last_o;

    modport master (
        output csr_req_o, csr_access_o, csr_addr_o, csr_wdata_o, csr_op_o,
        output out_valid_o, out_data_o, out_index_o, out_last_o,
        input  csr_gnt_i, csr_rdata_i, out_ready_i
    );

    modport slave (
        input  csr_req_o, csr_access_o, csr_addr_o, csr_wdata_o, csr_op_o,
        input  out_valid_o, out_data_o, out_index_o, out_last_o,
        output csr_gnt_i, csr_rdata_i, out_ready_i
    );
endinterface

// File: rtl/riscv_perf_dump.sv
// Performance counter dump engine. It saves the counter mode register and freezes counting.
// It then streams every counter out, optionally clears them all, and restores the mode register.
module riscv_perf_dump #(
    parameter int unsigned N_COUNTERS = 10
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start_i,
    input  logic               clear_i,
    output logic               busy_o,
    output logic               done_o,
    riscv_perf_dump_if.master  bus
);
    localparam logic [1:0]  CSR_OP_NONE  = 2'b00;
    localparam logic [1:0]  CSR_OP_WRITE = 2'b01;
    localparam logic [11:0] CSR_PCMR     = 12'h7A1;
    localparam logic [11:0] CSR_PCCR0    = 12'h780;
    localparam logic [11:0] CSR_PCCR_ALL = 12'h79F;
    localparam logic [4:0]  LAST_IDX     = 5'(N_COUNTERS - 1);

    typedef enum logic [2:0] {IDLE, SAVE, FREEZE, READ, OUT, CLEAR, RESTORE, DONE} state_e;

    state_e      state_q, state_d;
    logic [4:0]  idx_q, idx_d;
    logic        clear_q, clear_d;
    logic [1:0]  saved_pcmr_q, saved_pcmr_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        csr_req_q, csr_req_d;
    logic [11:0] csr_addr_q, csr_addr_d;
    logic [31:0] csr_wdata_q, csr_wdata_d;
    logic [1:0]  csr_op_q, csr_op_d;
    logic        out_valid_q, out_valid_d;
    logic [31:0] out_data_q, out_data_d;
    logic [4:0]  out_index_q, out_index_d;
    logic        out_last_q, out_last_d;

    logic xfer;
    logic accept;

    assign xfer   = csr_req_q & bus.csr_gnt_i;
    assign accept = out_valid_q & bus.out_ready_i;

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        clear_d      = clear_q;
        saved_pcmr_d = saved_pcmr_q;
        out_data_d   = out_data_q;
        out_index_d  = out_index_q;
        case (state_q)
            IDLE: if (start_i) begin
                clear_d = clear_i;
                state_d = SAVE;
            end
            SAVE: if (xfer) begin
                saved_pcmr_d = bus.csr_rdata_i[1:0];
                state_d      = FREEZE;
            end
            FREEZE: if (xfer) begin
                idx_d   = '0;
                state_d = READ;
            end
            READ: if (xfer) begin
                out_data_d  = bus.csr_rdata_i;
                out_index_d = idx_q;
                state_d     = OUT;
            end
            OUT: if (accept) begin
                if (idx_q == LAST_IDX) begin
                    state_d = clear_q ? CLEAR : RESTORE;
                end else begin
                    idx_d   = idx_q + 5'd1;
                    state_d = READ;
                end
            end
            CLEAR:   if (xfer) state_d = RESTORE;
            RESTORE: if (xfer) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs are decoded from the next state so that every port comes straight from a flop.
    always_comb begin
        busy_d      = (state_d != IDLE);
        done_d      = (state_d == DONE);
        out_valid_d = (state_d == OUT);
        out_last_d  = (state_d == OUT) && (idx_d == LAST_IDX);
        csr_req_d   = 1'b0;
        csr_addr_d  = '0;
        csr_wdata_d = '0;
        csr_op_d    = CSR_OP_NONE;
        case (state_d)
            SAVE: begin
                csr_req_d  = 1'b1;
                csr_addr_d = CSR_PCMR;
            end
            FREEZE: begin
                csr_req_d  = 1'b1;
                csr_addr_d = CSR_PCMR;
                csr_op_d   = CSR_OP_WRITE;
            end
            READ: begin
                csr_req_d  = 1'b1;
                csr_addr_d = CSR_PCCR0 + 12'(idx_d);
            end
            CLEAR: begin
                csr_req_d  = 1'b1;
                csr_addr_d = CSR_PCCR_ALL;
                csr_op_d   = CSR_OP_WRITE;
            end
            RESTORE: begin
                csr_req_d   = 1'b1;
                csr_addr_d  = CSR_PCMR;
                csr_op_d    = CSR_OP_WRITE;
                csr_wdata_d = {30'b0, saved_pcmr_d};
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            idx_q        <= '0;
            clear_q      <= 1'b0;
            saved_pcmr_q <= 2'b00;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            csr_req_q    <= 1'b0;
            csr_addr_q   <= '0;
            csr_wdata_q  <= '0;
            csr_op_q     <= CSR_OP_NONE;
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            out_index_q  <= '0;
            out_last_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            clear_q      <= clear_d;
            saved_pcmr_q <= saved_pcmr_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            csr_req_q    <= csr_req_d;
            csr_addr_q   <= csr_addr_d;
            csr_wdata_q  <= csr_wdata_d;
            csr_op_q     <= csr_op_d;
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            out_index_q  <= out_index_d;
            out_last_q   <= out_last_d;
        end
    end

    assign busy_o           = busy_q;
    assign done_o           = done_q;
    assign bus.csr_req_o    = csr_req_q;
    assign bus.csr_access_o = csr_req_q;
    assign bus.csr_addr_o   = csr_addr_q;
    assign bus.csr_wdata_o  = csr_wdata_q;
    assign bus.csr_op_o     = csr_op_q;
    assign bus.out_valid_o  = out_valid_q;
    assign bus.out_data_o   = out_data_q;
    assign bus.out_index_o  = out_index_q;
    assign bus.out_last_o   = out_last_q;
endmodule

// File: tb/tb_riscv_perf_dump.sv
// Bench for riscv_perf_dump: a counter CSR block model plus scoreboards of expected CSR transfers and output words.
// A 10-counter and a 1-counter instance are exercised.
module tb_riscv_perf_dump;
    localparam logic [1:0] OP_NONE  = 2'b00;
    localparam logic [1:0] OP_WRITE = 2'b01;

    typedef struct packed {logic [11:0] addr; logic [1:0] op; logic [31:0] wdata;} csr_t;
    typedef struct packed {logic [31:0] data; logic [4:0] idx; logic last;} word_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n = 1'b0;
    logic start0 = 1'b0, clear0 = 1'b0, busy0, done0;
    logic start1 = 1'b0, clear1 = 1'b0, busy1, done1;
    logic gnt0 = 1'b0, rdy0 = 1'b0;

    riscv_perf_dump_if ifc0 ();
    riscv_perf_dump_if ifc1 ();

    riscv_perf_dump #(.N_COUNTERS(10)) dut0 (
        .clk(clk), .rst_n(rst_n), .start_i(start0), .clear_i(clear0),
        .busy_o(busy0), .done_o(done0), .bus(ifc0.master)
    );
    riscv_perf_dump #(.N_COUNTERS(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start_i(start1), .clear_i(clear1),
        .busy_o(busy1), .done_o(done1), .bus(ifc1.master)
    );

    // Counter CSR block models: combinational read, writes committed at the granted edge
    logic [31:0] cnt0 [32];
    logic [1:0]  pcmr0 = 2'b00;
    logic [31:0] cnt1 = 32'h0;
    logic [1:0]  pcmr1 = 2'b00;
    logic [31:0] rd0, rd1;

    always_comb begin
        rd0 = 32'h0;
        if (ifc0.csr_addr_o == 12'h7A1) rd0 = {30'b0, pcmr0};
        else if (ifc0.csr_addr_o >= 12'h780 && ifc0.csr_addr_o <= 12'h79E) rd0 = cnt0[ifc0.csr_addr_o[4:0]];
    end
    always_comb begin
        rd1 = 32'h0;
        if (ifc1.csr_addr_o == 12'h7A1) rd1 = {30'b0, pcmr1};
        else if (ifc1.csr_addr_o == 12'h780) rd1 = cnt1;
    end

    assign ifc0.csr_rdata_i = rd0;
    assign ifc0.csr_gnt_i   = gnt0;
    assign ifc0.out_ready_i = rdy0;
    assign ifc1.csr_rdata_i = rd1;
    assign ifc1.csr_gnt_i   = 1'b1;
    assign ifc1.out_ready_i = 1'b1;

    csr_t  exp_csr_q[$];
    word_t exp_word_q[$];
    csr_t  exp_csr1_q[$];
    word_t exp_word1_q[$];

    int n_assert = 0;
    int n_fail = 0;
    int gnt_mode = 0;
    int rdy_mode = 0;
    int wait_cnt = 0;
    int stall_cnt = 0;
    int done_cnt = 0;
    bit mon_en = 1'b0;
    bit word_pending = 1'b0;
    csr_t  held_csr;
    word_t held_word;

    // Monitor for dut0. It drives gnt and ready for the next edge and checks against the scoreboards.
    always @(negedge clk) begin
        csr_t  cur, e;
        word_t w, ew;
        if (!rst_n) begin
            wait_cnt = 0;
            word_pending = 1'b0;
        end else if (mon_en) begin
            cur = '{ifc0.csr_addr_o, ifc0.csr_op_o, ifc0.csr_wdata_o};
            if (ifc0.csr_req_o) begin
                n_assert++;
                if (ifc0.csr_access_o !== 1'b1 || ifc0.out_valid_o !== 1'b0) begin
                    n_fail++;
                    $display("FAIL csr_req_side: access=%b valid=%b required access=1 valid=0", ifc0.csr_access_o, ifc0.out_valid_o);
                end
                if (wait_cnt > 0) begin
                    n_assert++;
                    if (cur !== held_csr) begin
                        n_fail++;
                        $display("FAIL csr_hold: got %h required %h", cur, held_csr);
                    end
                end
                if (gnt_mode == 1 && wait_cnt < 3) begin
                    gnt0 = 1'b0;
                    held_csr = cur;
                    wait_cnt++;
                end else begin
                    gnt0 = 1'b1;
                    wait_cnt = 0;
                    n_assert++;
                    if (exp_csr_q.size() == 0) begin
                        n_fail++;
                        $display("FAIL csr_unexpected: addr=%h op=%0d wdata=%h required no transfer", cur.addr, cur.op, cur.wdata);
                    end else begin
                        e = exp_csr_q.pop_front();
                        if (cur.addr !== e.addr || cur.op !== e.op || (e.op == OP_WRITE && cur.wdata !== e.wdata)) begin
                            n_fail++;
                            $display("FAIL csr_xfer: got addr=%h op=%0d wdata=%h required addr=%h op=%0d wdata=%h",
                                     cur.addr, cur.op, cur.wdata, e.addr, e.op, e.wdata);
                        end
                    end
                    if (cur.op == OP_WRITE && cur.addr == 12'h7A1) pcmr0 = cur.wdata[1:0];
                    if (cur.op == OP_WRITE && cur.addr == 12'h79F) for (int k = 0; k < 32; k++) cnt0[k] = 32'h0;
                end
            end else begin
                gnt0 = (gnt_mode == 0);
                n_assert++;
                if (cur !== '0 || ifc0.csr_access_o !== 1'b0) begin
                    n_fail++;
                    $display("FAIL csr_idle: got %h access=%b required 0", cur, ifc0.csr_access_o);
                end
            end
            if (ifc0.out_valid_o) begin
                w = '{ifc0.out_data_o, ifc0.out_index_o, ifc0.out_last_o};
                if (word_pending) begin
                    n_assert++;
                    if (w !== held_word) begin
                        n_fail++;
                        $display("FAIL word_hold: got %h required %h", w, held_word);
                    end
                end
                if (rdy_mode == 0 || stall_cnt == 0) begin
                    rdy0 = 1'b1;
                    word_pending = 1'b0;
                    stall_cnt = $urandom_range(0, 5);
                    n_assert++;
                    if (exp_word_q.size() == 0) begin
                        n_fail++;
                        $display("FAIL word_unexpected: got data=%h idx=%0d required none", w.data, w.idx);
                    end else begin
                        ew = exp_word_q.pop_front();
                        if (w !== ew) begin
                            n_fail++;
                            $display("FAIL word: got data=%h idx=%0d last=%b required data=%h idx=%0d last=%b",
                                     w.data, w.idx, w.last, ew.data, ew.idx, ew.last);
                        end
                    end
                end else begin
                    rdy0 = 1'b0;
                    stall_cnt--;
                    held_word = w;
                    word_pending = 1'b1;
                end
            end else begin
                rdy0 = (rdy_mode == 0);
                word_pending = 1'b0;
            end
            if (done0) done_cnt++;
        end
    end

    task automatic preset(input logic [1:0] pm);
        for (int k = 0; k < 32; k++) cnt0[k] = 32'(k * 16 + 1);
        pcmr0 = pm;
    endtask

    task automatic push_expected(input bit clr);
        exp_csr_q.push_back('{12'h7A1, OP_NONE, 32'h0});
        exp_csr_q.push_back('{12'h7A1, OP_WRITE, 32'h0});
        for (int k = 0; k < 10; k++) begin
            exp_csr_q.push_back('{12'h780 + 12'(k), OP_NONE, 32'h0});
            exp_word_q.push_back('{cnt0[k], 5'(k), k == 9});
        end
        if (clr) exp_csr_q.push_back('{12'h79F, OP_WRITE, 32'h0});
        exp_csr_q.push_back('{12'h7A1, OP_WRITE, {30'b0, pcmr0}});
    endtask

    task automatic run_dump(input bit clr, input int extra_start, input bit start_in_done, input int exp_lat);
        int cyc;
        done_cnt = 0;
        push_expected(clr);
        @(negedge clk);
        start0 = 1'b1;
        clear0 = clr;
        cyc = 0;
        while (cyc < 2000) begin
            @(negedge clk);
            cyc++;
            start0 = (cyc == extra_start);
            clear0 = 1'b0;
            if (done0) break;
            n_assert++;
            if (busy0 !== 1'b1) begin
                n_fail++;
                $display("FAIL busy: cycle %0d got %b required 1", cyc, busy0);
            end
        end
        n_assert++;
        if (done0 !== 1'b1 || busy0 !== 1'b1) begin
            n_fail++;
            $display("FAIL done_timeout: done=%b busy=%b after %0d cycles required 1 1", done0, busy0, cyc);
        end
        if (exp_lat >= 0) begin
            n_assert++;
            if (cyc != exp_lat) begin
                n_fail++;
                $display("FAIL latency: got %0d required %0d", cyc, exp_lat);
            end
        end
        if (start_in_done) start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        repeat (3) begin
            n_assert++;
            if (busy0 !== 1'b0 || done0 !== 1'b0) begin
                n_fail++;
                $display("FAIL idle_after: busy=%b done=%b required 0 0", busy0, done0);
            end
            @(negedge clk);
        end
        n_assert++;
        if (exp_csr_q.size() != 0 || exp_word_q.size() != 0 || done_cnt != 1) begin
            n_fail++;
            $display("FAIL leftovers: csr=%0d words=%0d done_pulses=%0d required 0 0 1",
                     exp_csr_q.size(), exp_word_q.size(), done_cnt);
        end
        $display("dump clr=%0d cycles=%0d pcmr_after=%0d", clr, cyc, pcmr0);
    endtask

    task automatic check_all_zero(input string tag);
        n_assert++;
        if ({busy0, done0, ifc0.csr_req_o, ifc0.csr_access_o, ifc0.csr_addr_o, ifc0.csr_wdata_o, ifc0.csr_op_o,
             ifc0.out_valid_o, ifc0.out_data_o, ifc0.out_index_o, ifc0.out_last_o,
             busy1, done1, ifc1.csr_req_o, ifc1.out_valid_o, ifc1.out_data_o} !== '0) begin
            n_fail++;
            $display("FAIL %s: outputs not all zero busy=%b req=%b addr=%h op=%0d valid=%b data=%h idx=%0d required 0",
                     tag, busy0, ifc0.csr_req_o, ifc0.csr_addr_o, ifc0.csr_op_o, ifc0.out_valid_o,
                     ifc0.out_data_o, ifc0.out_index_o);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check_all_zero("reset_in");
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check_all_zero("reset_after");
        $display("reset checked");
    endtask

    task automatic test_basic();
        preset(2'b11);
        run_dump(1'b0, -1, 1'b0, 24);
    endtask

    task automatic test_clear();
        preset(2'b11);
        run_dump(1'b1, -1, 1'b0, 25);
        for (int k = 0; k < 10; k++) cnt0[k] = 32'hFFFF_FFFF;
        for (int k = 0; k < 10; k++) cnt0[k] = 32'h0;
        run_dump(1'b0, -1, 1'b0, 24);
    endtask

    task automatic test_backpressure();
        preset(2'b10);
        rdy_mode = 1;
        run_dump(1'b0, -1, 1'b0, -1);
        rdy_mode = 0;
    endtask

    task automatic test_gnt_wait();
        preset(2'b01);
        gnt_mode = 1;
        run_dump(1'b1, -1, 1'b0, -1);
        gnt_mode = 0;
    endtask

    task automatic test_edge_starts();
        preset(2'b11);
        run_dump(1'b0, 5, 1'b1, 24);
    endtask

    task automatic test_reset_mid();
        int cyc;
        preset(2'b11);
        push_expected(1'b0);
        @(negedge clk);
        start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        cyc = 0;
        while (!(ifc0.out_valid_o && ifc0.out_index_o == 5'd4) && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        n_assert++;
        if (!(ifc0.out_valid_o && ifc0.out_index_o == 5'd4)) begin
            n_fail++;
            $display("FAIL reach_idx4: valid=%b idx=%0d required 1 4", ifc0.out_valid_o, ifc0.out_index_o);
        end
        #2 rst_n = 1'b0;
        #1 check_all_zero("reset_async");
        @(negedge clk);
        check_all_zero("reset_held");
        n_assert++;
        if (pcmr0 !== 2'b00) begin
            n_fail++;
            $display("FAIL pcmr_not_restored: got %0d required 0", pcmr0);
        end
        exp_csr_q.delete();
        exp_word_q.delete();
        #2 rst_n = 1'b1;
        @(negedge clk);
        check_all_zero("reset_idle");
        preset(2'b11);
        run_dump(1'b0, -1, 1'b0, 24);
    endtask

    task automatic test_n1();
        int cyc;
        csr_t  cur, e;
        word_t w, ew;
        pcmr1 = 2'b01;
        cnt1 = 32'hABCD_1234;
        exp_csr1_q.push_back('{12'h7A1, OP_NONE, 32'h0});
        exp_csr1_q.push_back('{12'h7A1, OP_WRITE, 32'h0});
        exp_csr1_q.push_back('{12'h780, OP_NONE, 32'h0});
        exp_csr1_q.push_back('{12'h7A1, OP_WRITE, 32'h1});
        exp_word1_q.push_back('{32'hABCD_1234, 5'd0, 1'b1});
        @(negedge clk);
        start1 = 1'b1;
        cyc = 0;
        while (cyc < 100) begin
            @(negedge clk);
            start1 = 1'b0;
            cyc++;
            if (ifc1.csr_req_o) begin
                cur = '{ifc1.csr_addr_o, ifc1.csr_op_o, ifc1.csr_wdata_o};
                n_assert++;
                if (exp_csr1_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL n1_csr_unexpected: addr=%h op=%0d required none", cur.addr, cur.op);
                end else begin
                    e = exp_csr1_q.pop_front();
                    if (cur.addr !== e.addr || cur.op !== e.op || (e.op == OP_WRITE && cur.wdata !== e.wdata)) begin
                        n_fail++;
                        $display("FAIL n1_csr: got addr=%h op=%0d wdata=%h required addr=%h op=%0d wdata=%h",
                                 cur.addr, cur.op, cur.wdata, e.addr, e.op, e.wdata);
                    end
                end
                if (cur.op == OP_WRITE && cur.addr == 12'h7A1) pcmr1 = cur.wdata[1:0];
            end
            if (ifc1.out_valid_o) begin
                w = '{ifc1.out_data_o, ifc1.out_index_o, ifc1.out_last_o};
                n_assert++;
                if (exp_word1_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL n1_word_unexpected: got data=%h required none", w.data);
                end else begin
                    ew = exp_word1_q.pop_front();
                    if (w !== ew) begin
                        n_fail++;
                        $display("FAIL n1_word: got data=%h idx=%0d last=%b required data=%h idx=%0d last=%b",
                                 w.data, w.idx, w.last, ew.data, ew.idx, ew.last);
                    end
                end
            end
            if (done1) break;
        end
        n_assert++;
        if (done1 !== 1'b1 || exp_csr1_q.size() != 0 || exp_word1_q.size() != 0 || pcmr1 !== 2'b01) begin
            n_fail++;
            $display("FAIL n1_end: done=%b csr_left=%0d words_left=%0d pcmr=%0d required 1 0 0 1",
                     done1, exp_csr1_q.size(), exp_word1_q.size(), pcmr1);
        end
        $display("n1 dump cycles=%0d pcmr_after=%0d", cyc, pcmr1);
    endtask

    initial begin
        for (int k = 0; k < 32; k++) cnt0[k] = 32'h0;
        test_reset();
        mon_en = 1'b1;
        test_basic();
        test_clear();
        test_backpressure();
        test_gnt_wait();
        test_edge_starts();
        test_reset_mid();
        test_n1();
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule

// File: doc/riscv_perf_dump.md
Name: riscv_perf_dump

Overview:
CSR-side initiator that snapshots the core's performance counter CSRs and streams them out over a valid/ready port, for debug or cluster-level profiling.
- On a start pulse it saves the counter mode register (0x7A1) and freezes counting.
- It then reads counters 0x780..0x780+N_COUNTERS-1 in order, optionally clears all counters through 0x79F, and restores the mode register.
- It masters the core's SRAM-like CSR port through an external arbiter (req/gnt) that sits in front of the counter CSR block.

Parameters:
N_COUNTERS, 10, number of counters dumped (1..31); counter k lives at CSR address 12'h780+k.

Ports:
clk  input  1  clock
rst_n  input  1  reset, asynchronous, active-low
start_i  input  1  single-cycle dump request; ignored while busy_o=1
clear_i  input  1  sampled with start_i; 1 = zero all counters after the dump
busy_o  output  1  high from the cycle after an accepted start until the done_o cycle, inclusive
done_o  output  1  one-cycle pulse when the sequence completes
csr_req_o  output  1  request for the CSR port
csr_gnt_i  input  1  port granted this cycle; a CSR transfer occurs only when req&gnt
csr_access_o  output  1  CSR access strobe; equals csr_req_o
csr_addr_o  output  12  CSR address
csr_wdata_o  output  32  CSR write data
csr_op_o  output  2  CSR_OP_NONE/WRITE/SET/CLEAR (shared CSR op defines)
csr_rdata_i  input  32  combinational read data, valid in the req&gnt cycle
out_valid_o  output  1  output word valid
out_ready_i  input  1  consumer accepts the word
out_data_o  output  32  counter value
out_index_o  output  5  counter index k
out_last_o  output  1  high on the word with k=N_COUNTERS-1

Behaviour:
- Reset values: all outputs 0; csr_op_o=CSR_OP_NONE; FSM in IDLE; saved_pcmr=2'b00.
- CSR transfer rule: a transfer completes in the cycle with csr_req_o & csr_gnt_i.
  - Read data is captured at that clock edge.
  - The responder commits writes at the same edge.
  - Addr, op and wdata are held stable while req=1 and gnt=0; the request is never withdrawn.
- FSM states: IDLE, SAVE, FREEZE, READ, OUT, CLEAR, RESTORE, DONE.
- IDLE: on start_i, latch clear_q=clear_i; next state SAVE.
- SAVE: req, addr 0x7A1, op NONE. On grant, saved_pcmr<=rdata[1:0]; next FREEZE.
- FREEZE: req, addr 0x7A1, op WRITE, wdata 0, which stops all counting. On grant, idx<=0; next READ.
- READ: req, addr 0x780+idx, op NONE. On grant, capture rdata into the out register, set out_valid; next OUT.
- OUT: csr_req_o=0. out_valid_o=1 holding data, index=idx, last=(idx==N_COUNTERS-1), all stable until out_ready_i. On accept, out_valid_o drops the next cycle:
  - if not last: idx+1, next READ;
  - if last and clear_q: next CLEAR;
  - if last and not clear_q: next RESTORE.
- Throughput: minimum 2 cycles per word (READ grant, OUT accept). Backpressure only stalls in OUT.
- CLEAR: req, addr 0x79F, op WRITE, wdata 0, which zeroes every counter. On grant, next RESTORE.
- RESTORE: req, addr 0x7A1, op WRITE, wdata {30'b0, saved_pcmr}. On grant, next DONE.
- DONE: done_o=1 for one cycle; next IDLE.
- Start handling: start_i in the DONE cycle is ignored; a new start is accepted only in IDLE.
- Counter values are read while frozen, so the snapshot is consistent. Saturation/enable bits are restored exactly.
- idx is 5 bits. N_COUNTERS=1 makes the first word last. No wrap past N_COUNTERS-1.
- Reset mid-sequence returns to IDLE with all outputs 0. The counter block's mode register is not restored by this block.
- Outside req cycles: csr_addr_o=0, csr_wdata_o=0, csr_op_o=NONE.
- out_data_o is registered and holds its last value when out_valid_o=0.

Test Plan:
1. Default params, gnt tied 1, ready tied 1, counters preset k*16+1, PCMR=2'b11, start with clear=0.
   - Required: 10 words, data 1,17,...,145, index 0..9, last on index 9.
   - Required CSR sequence: read 7A1, write 7A1=0, 10 reads, write 7A1=3, then done.
   - Total latency from start to done: 24 cycles.
2. Same as scenario 1 with clear=1.
   - Required: a write to 79F with data 0 after word 9 and before the restore.
   - Counters read 0 afterwards; done_o pulses once.
3. Random out_ready_i stalls, 0-5 cycles per word.
   - Required: no word lost or duplicated; data/index/last stable while valid&!ready; no CSR req during OUT.
4. csr_gnt_i low for 3 cycles on each request.
   - Required: addr/op/wdata stable during the wait; each transfer occurs exactly once; output values unchanged.
5. Edge starts and reset.
   - start while busy: ignored.
   - start in the DONE cycle: ignored.
   - rst_n asserted during OUT at idx=4: all outputs 0 immediately (asynchronous), IDLE afterwards, and the next start performs a full dump.
6. N_COUNTERS=1 with PCMR initially 2'b01.
   - Required: a single word with index 0 and last=1; the restore writes wdata=1.
